my_ram_be_pipe: RTL and testbench
=================================

# my_ram_be_pipe

Parametrised simple dual-port RAM, the successor to the team's single-cycle dual-port RAM:
- one write port with per-byte write enables and one read port;
- selectable read latency of 1 or 2 cycles, with a read-valid pipeline;
- optional same-address read-during-write forwarding;
- optional per-byte parity.

It sits under the RAM-based FIFOs and packet buffers as their storage element.

## Interface
Parameters:
- DATA_W, 32, data width; must be a multiple of BYTE_W
- BYTE_W, 8, write-enable granularity in bits
- DEPTH, 16, number of words; need not be a power of 2
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- BYPASS, 1, 1 = same-address read-during-write returns the newly written bytes; 0 = returns the old word
- ADDR_W, $clog2(DEPTH), dependent: address width
- NBYTES, DATA_W/BYTE_W, dependent: number of byte lanes

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- i_ramen  in  1  block enable; acts as a clock enable for the whole block
- i_wren  in  1  write request
- i_wbe  in  NBYTES  byte write enables; bit k covers i_wdata[k*BYTE_W +: BYTE_W]
- i_waddr  in  ADDR_W  write address
- i_wdata  in  DATA_W  write data
- i_rden  in  1  read request
- i_raddr  in  ADDR_W  read address
- o_rdata  out  DATA_W  read data
- o_rvalid  out  1  one-cycle strobe marking o_rdata valid
- o_perr  out  1  parity error, qualified by o_rvalid (only with RAM_PARITY_EN)
- i_perr_inj  in  1  parity error injection (only with RAM_PARITY_EN)

## Operation
- **Write.** Occurs on a rising edge when i_ramen & i_wren & !rst.
  - Only lanes with i_wbe[k]=1 are updated; other lanes keep their contents.
  - i_wbe = 0 is a legal no-op.
- **Read.**
  - Accepted on an edge when i_ramen & i_rden & !rst.
  - Stage 1 captures array data.
  - With RD_LAT=2, stage 2 re-registers it before it drives o_rdata.
- **Read-valid pipeline.** A RD_LAT-deep valid shift register tracks accepted reads; o_rvalid is its last stage.
- **Read-during-write to the same address, same cycle:**
  - BYPASS=1: the returned word is the merge of new bytes (i_wbe[k]=1) and old bytes (i_wbe[k]=0).
  - BYPASS=0: the returned word is entirely the pre-write contents.
- **Out-of-range addresses** (address >= DEPTH, non-power-of-2 DEPTH only):
  - a write is dropped with no aliasing;
  - a read returns all-zero data with o_rvalid still asserted.
- **i_ramen low.** All registers hold: the array, the data pipeline, the valid pipeline and o_perr. o_rvalid therefore holds its last value; consumers must gate it with i_ramen.
- **Output hold.** o_rdata holds its last value when no new read completes.
- **Array contents** are never reset. Reading an unwritten location returns X in simulation and no defined value is required.

## Timing
- **Reset values:** o_rdata=0, o_rvalid=0, o_perr=0, all pipeline valid bits=0.
- **rst dominates** i_ramen, i_wren and i_rden. In a cycle with rst high, no write or read is accepted.
- **Reset mid-operation:** in-flight reads are discarded, with no o_rvalid for them after reset. Array contents written before reset are retained.
- **Read latency:** read accepted at edge t gives o_rdata/o_rvalid at edge t+RD_LAT, assuming i_ramen stays high.
- **Throughput:** one read and one write per cycle, with no bubbles.
- **Write-then-read:** a write at edge t is visible to a read accepted at edge t+1 regardless of BYPASS.

## Configuration
Macro: RAM_PARITY_EN.

Defined:
- One even-parity bit per byte lane is stored alongside the data. The parity bit is written with its lane.
- When i_perr_inj=1 during a write, byte lane 0 parity is stored inverted (lane 0 must be enabled).
- On read, parity is recomputed over the returned word.
- o_perr is asserted together with o_rvalid if any lane mismatches; it is 0 whenever o_rvalid=0.
- Bypassed lanes use freshly computed parity. Injection applies to the bypassed lane as well.
- Out-of-range reads report o_perr=0.

Undefined:
- No parity storage.
- o_perr and i_perr_inj are absent from the port list.

## Test plan
- **Byte-enable merge.** DATA_W=32: write 0xAABBCCDD to addr 3 with wbe=4'hF, then 0x11223344 with wbe=4'b0101, then read addr 3 -> o_rdata=0xAA22CC44, o_rvalid 1 cycle later (RD_LAT=1) or 2 cycles later (RD_LAT=2).
- **Back-to-back reads.** Reads of addrs 0..15 on consecutive cycles after filling mem[i]=i*0x01010101 -> 16 consecutive o_rvalid pulses, data in order, no gaps, for both RD_LAT values.
- **Read-during-write, same address.** mem[5]=0x00000000; same cycle write 0xFFFFFFFF with wbe=4'b0011 and read addr 5 -> 0x0000FFFF with BYPASS=1, 0x00000000 with BYPASS=0.
- **Enable and reset.** Drop i_ramen for 3 cycles while a read is in flight -> o_rdata/o_rvalid frozen, then completes on resume. Assert rst with 2 reads in flight at RD_LAT=2 -> no o_rvalid afterwards; earlier-written data still readable.
- **Out-of-range.** DEPTH=12: write 0x12345678 to addr 13 and read addr 13 -> o_rdata=0, o_rvalid=1; mem[1] unchanged.
- **Parity** (RAM_PARITY_EN): write 0xCAFEF00D with i_perr_inj=1 to addr 7, read -> o_perr=1 with o_rvalid. Rewrite without injection -> o_perr=0.

Source files
------------

// File: rtl/my_ram_be_pipe.sv
// Byte-enabled simple dual-port RAM with a 1- or 2-cycle registered read path and read-valid pipeline.
// Optional feature macro RAM_PARITY_EN: per-lane even parity, adds o_perr and i_perr_inj.
module my_ram_be_pipe #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NBYTES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ramen,
  input  logic              i_wren,
  input  logic [NBYTES-1:0] i_wbe,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rden,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
`ifdef RAM_PARITY_EN
  ,
  output logic              o_perr,
  input  logic              i_perr_inj
`endif
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_go;
  logic              rd_go;
  logic              wr_in;
  logic              rd_in;
  logic              hit;
  logic [DATA_W-1:0] rd_word;

  assign wr_go = i_ramen & i_wren & ~rst;
  assign rd_go = i_ramen & i_rden & ~rst;
  // Addresses past DEPTH exist only for non-power-of-2 depths; they must never alias.
  assign wr_in = 32'(i_waddr) < 32'(DEPTH);
  assign rd_in = 32'(i_raddr) < 32'(DEPTH);
  assign hit   = (BYPASS != 0) && wr_go && wr_in && (i_waddr == i_raddr);

`ifdef RAM_PARITY_EN
  logic [NBYTES-1:0] par_q [DEPTH];
  logic [NBYTES-1:0] wr_par;
  logic [NBYTES-1:0] rd_par;
  logic              rd_perr;

  always_comb begin
    for (int k = 0; k < NBYTES; k++) begin
      wr_par[k] = ^i_wdata[k*BYTE_W +: BYTE_W];
    end
    wr_par[0] = wr_par[0] ^ i_perr_inj;
  end
`endif

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_go && wr_in) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_wbe[k]) begin
          mem_q[i_waddr][k*BYTE_W +: BYTE_W] <= i_wdata[k*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
          par_q[i_waddr][k] <= wr_par[k];
`endif
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
`ifdef RAM_PARITY_EN
    rd_par = '0;
`endif
    if (rd_in) begin
      rd_word = mem_q[i_raddr];
`ifdef RAM_PARITY_EN
      rd_par = par_q[i_raddr];
`endif
      for (int k = 0; k < NBYTES; k++) begin
        if (hit && i_wbe[k]) begin
          rd_word[k*BYTE_W +: BYTE_W] = i_wdata[k*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
          rd_par[k] = wr_par[k];
`endif
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  always_comb begin
    rd_perr = 1'b0;
    for (int k = 0; k < NBYTES; k++) begin
      if (rd_par[k] != ^rd_word[k*BYTE_W +: BYTE_W]) begin
        rd_perr = 1'b1;
      end
    end
  end
`endif

  logic              vld1_q;
  logic              vld1_d;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data1_d;
`ifdef RAM_PARITY_EN
  logic              perr1_q;
  logic              perr1_d;
`endif

  // Stage 1: everything freezes while i_ramen is low; data holds when no read lands.
  always_comb begin
    vld1_d  = vld1_q;
    data1_d = data1_q;
`ifdef RAM_PARITY_EN
    perr1_d = perr1_q;
`endif
    if (i_ramen) begin
      vld1_d = rd_go;
`ifdef RAM_PARITY_EN
      perr1_d = rd_go & rd_perr;
`endif
      if (rd_go) begin
        data1_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      data1_q <= '0;
`ifdef RAM_PARITY_EN
      perr1_q <= 1'b0;
`endif
    end else begin
      vld1_q  <= vld1_d;
      data1_q <= data1_d;
`ifdef RAM_PARITY_EN
      perr1_q <= perr1_d;
`endif
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic              vld2_q;
      logic              vld2_d;
      logic [DATA_W-1:0] data2_q;
      logic [DATA_W-1:0] data2_d;
`ifdef RAM_PARITY_EN
      logic              perr2_q;
      logic              perr2_d;
`endif

      always_comb begin
        vld2_d  = vld2_q;
        data2_d = data2_q;
`ifdef RAM_PARITY_EN
        perr2_d = perr2_q;
`endif
        if (i_ramen) begin
          vld2_d = vld1_q;
`ifdef RAM_PARITY_EN
          perr2_d = vld1_q & perr1_q;
`endif
          if (vld1_q) begin
            data2_d = data1_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld2_q  <= 1'b0;
          data2_q <= '0;
`ifdef RAM_PARITY_EN
          perr2_q <= 1'b0;
`endif
        end else begin
          vld2_q  <= vld2_d;
          data2_q <= data2_d;
`ifdef RAM_PARITY_EN
          perr2_q <= perr2_d;
`endif
        end
      end

      assign o_rvalid = vld2_q;
      assign o_rdata  = data2_q;
`ifdef RAM_PARITY_EN
      assign o_perr   = perr2_q;
`endif
    end else begin : g_lat1
      assign o_rvalid = vld1_q;
      assign o_rdata  = data1_q;
`ifdef RAM_PARITY_EN
      assign o_perr   = perr1_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_my_ram_be_pipe.sv
// Bench for my_ram_be_pipe: a 16-deep/latency-1/bypass instance and a 12-deep/latency-2/no-bypass
// instance share one stimulus stream and are compared each cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_my_ram_be_pipe;

  localparam int A_DEPTH = 16;
  localparam int A_LAT   = 1;
  localparam int A_BYP   = 1;
  localparam int B_DEPTH = 12;
  localparam int B_LAT   = 2;
  localparam int B_BYP   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ramen;
  logic        wren;
  logic        rden;
  logic        perrInj;
  logic [3:0]  wbe;
  logic [3:0]  waddr;
  logic [3:0]  raddr;
  logic [31:0] wdata;
  logic [31:0] aRdata;
  logic [31:0] bRdata;
  logic        aRvalid;
  logic        bRvalid;
`ifdef RAM_PARITY_EN
  logic        aPerr;
  logic        bPerr;
`endif

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  my_ram_be_pipe #(.DATA_W(32), .BYTE_W(8), .DEPTH(A_DEPTH), .RD_LAT(A_LAT), .BYPASS(A_BYP)) uA (
    .clk(clk), .rst(rst), .i_ramen(ramen), .i_wren(wren), .i_wbe(wbe), .i_waddr(waddr),
    .i_wdata(wdata), .i_rden(rden), .i_raddr(raddr), .o_rdata(aRdata), .o_rvalid(aRvalid)
`ifdef RAM_PARITY_EN
    , .o_perr(aPerr), .i_perr_inj(perrInj)
`endif
  );

  my_ram_be_pipe #(.DATA_W(32), .BYTE_W(8), .DEPTH(B_DEPTH), .RD_LAT(B_LAT), .BYPASS(B_BYP)) uB (
    .clk(clk), .rst(rst), .i_ramen(ramen), .i_wren(wren), .i_wbe(wbe), .i_waddr(waddr),
    .i_wdata(wdata), .i_rden(rden), .i_raddr(raddr), .o_rdata(bRdata), .o_rvalid(bRvalid)
`ifdef RAM_PARITY_EN
    , .o_perr(bPerr), .i_perr_inj(perrInj)
`endif
  );

  function automatic int cfgDepth(input int c);
    return (c == 0) ? A_DEPTH : B_DEPTH;
  endfunction
  function automatic int cfgLat(input int c);
    return (c == 0) ? A_LAT : B_LAT;
  endfunction
  function automatic int cfgByp(input int c);
    return (c == 0) ? A_BYP : B_BYP;
  endfunction

  typedef struct {
    int          cfg;
    int          due;
    logic [31:0] data;
    bit          perr;
  } rdItem_t;

  rdItem_t     pend[$];
  rdItem_t     item;
  logic [31:0] refMem    [2][16];
  bit          refPoison [2][16];
  logic [31:0] expData   [2];
  bit          expVal    [2];
  bit          expPerr   [2];
  int          ecycle = 0;
  bit          found;

  // Reference model: reads are time-stamped with the enabled-cycle count at which they must emerge.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      for (int c = 0; c < 2; c++) begin
        expVal[c]  = 1'b0;
        expData[c] = '0;
        expPerr[c] = 1'b0;
      end
    end else if (ramen) begin
      for (int c = 0; c < 2; c++) begin
        if (rden) begin
          item.cfg  = c;
          item.due  = ecycle + cfgLat(c);
          item.data = '0;
          item.perr = 1'b0;
          if (int'(raddr) < cfgDepth(c)) begin
            item.data = refMem[c][raddr];
            item.perr = refPoison[c][raddr];
            if (cfgByp(c) != 0 && wren && waddr == raddr) begin
              for (int k = 0; k < 4; k++) begin
                if (wbe[k]) item.data[k*8 +: 8] = wdata[k*8 +: 8];
              end
              if (wbe[0]) item.perr = perrInj;
            end
          end
          pend.push_back(item);
        end
        if (wren && int'(waddr) < cfgDepth(c)) begin
          for (int k = 0; k < 4; k++) begin
            if (wbe[k]) refMem[c][waddr][k*8 +: 8] = wdata[k*8 +: 8];
          end
          if (wbe[0]) refPoison[c][waddr] = perrInj;
        end
      end
      ecycle++;
      for (int c = 0; c < 2; c++) begin
        found      = 1'b0;
        expVal[c]  = 1'b0;
        expPerr[c] = 1'b0;
        for (int i = 0; i < pend.size(); i++) begin
          if (!found && pend[i].cfg == c) begin
            found = 1'b1;
            if (pend[i].due == ecycle) begin
              expVal[c]  = 1'b1;
              expData[c] = pend[i].data;
              expPerr[c] = pend[i].perr;
              pend.delete(i);
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (checkOn) begin
      checkOutput("A.rvalid", {31'b0, aRvalid}, {31'b0, expVal[0]});
      checkOutput("A.rdata", aRdata, expData[0]);
      checkOutput("B.rvalid", {31'b0, bRvalid}, {31'b0, expVal[1]});
      checkOutput("B.rdata", bRdata, expData[1]);
`ifdef RAM_PARITY_EN
      checkOutput("A.perr", {31'b0, aPerr}, {31'b0, expPerr[0]});
      checkOutput("B.perr", {31'b0, bPerr}, {31'b0, expPerr[1]});
`endif
    end
  end

  task automatic applyStimulus(input bit r, input bit en, input bit we, input logic [3:0] be,
                               input logic [3:0] wa, input logic [31:0] wd,
                               input bit re, input logic [3:0] ra, input bit inj);
    @(negedge clk);
    rst     = r;
    ramen   = en;
    wren    = we;
    wbe     = be;
    waddr   = wa;
    wdata   = wd;
    rden    = re;
    raddr   = ra;
    perrInj = inj;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ramen = 1'b0; wren = 1'b0; rden = 1'b0; perrInj = 1'b0;
    wbe = '0; waddr = '0; raddr = '0; wdata = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    checkOutput("reset A.rvalid", {31'b0, aRvalid}, 32'h0);
    checkOutput("reset A.rdata", aRdata, 32'h0);
    checkOutput("reset B.rvalid", {31'b0, bRvalid}, 32'h0);
    checkOutput("reset B.rdata", bRdata, 32'h0);
    checkOn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'(i), 32'(i) * 32'h01010101, 1'b0, 4'h0, 1'b0);
    end

    // Byte-enable merge
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b0);
    idleCycle();
    checkOutput("merge A.rdata", aRdata, 32'hAA22CC44);
    checkOutput("merge A.rvalid", {31'b0, aRvalid}, 32'h1);
    idleCycle();
    checkOutput("merge B.rdata", bRdata, 32'hAA22CC44);
    checkOutput("merge B.rvalid", {31'b0, bRvalid}, 32'h1);

    // Back-to-back reads of every address
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b0);
    end
    repeat (3) idleCycle();

    // Same-address read-during-write
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 1'b0);
    idleCycle();
    checkOutput("rdw A.rdata", aRdata, 32'h0000FFFF);
    idleCycle();
    checkOutput("rdw B.rdata", bRdata, 32'h00000000);
    repeat (2) idleCycle();

    // Enable dropped for three edges while a read is in flight; ignored traffic meanwhile
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 4'd2, 32'hDEADBEEF, 1'b1, 4'd7, 1'b0);
    idleCycle();
    checkOutput("freeze A.rvalid", {31'b0, aRvalid}, 32'h1);
    checkOutput("freeze A.rdata", aRdata, 32'h02020202);
    checkOutput("freeze B.rvalid", {31'b0, bRvalid}, 32'h0);
    idleCycle();
    checkOutput("resume B.rvalid", {31'b0, bRvalid}, 32'h1);
    checkOutput("resume B.rdata", bRdata, 32'h02020202);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2, 1'b0);
    idleCycle();
    checkOutput("no write while disabled", aRdata, 32'h02020202);
    repeat (2) idleCycle();

    // Reset with reads in flight; write and read during reset must be ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd6, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 4'd9, 32'hBAD0BAD0, 1'b1, 4'd9, 1'b0);
    idleCycle();
    checkOutput("midreset A.rvalid", {31'b0, aRvalid}, 32'h0);
    checkOutput("midreset B.rvalid", {31'b0, bRvalid}, 32'h0);
    checkOutput("midreset B.rdata", bRdata, 32'h0);
    repeat (2) idleCycle();
    checkOutput("post-reset B.rvalid", {31'b0, bRvalid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd9, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("retained B.rdata", bRdata, 32'h09090909);

    // Out-of-range address on the 12-deep instance
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd13, 32'h12345678, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd13, 1'b0);
    idleCycle();
    checkOutput("oor A.rdata", aRdata, 32'h12345678);
    idleCycle();
    checkOutput("oor B.rdata", bRdata, 32'h0);
    checkOutput("oor B.rvalid", {31'b0, bRvalid}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("no alias B.rdata", bRdata, 32'h01010101);

`ifdef RAM_PARITY_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd7, 32'hCAFEF00D, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0);
    idleCycle();
    checkOutput("inj A.perr", {31'b0, aPerr}, 32'h1);
    idleCycle();
    checkOutput("inj B.perr", {31'b0, bPerr}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'd7, 32'hCAFEF00D, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0);
    idleCycle();
    checkOutput("clean A.perr", {31'b0, aPerr}, 32'h0);
    idleCycle();
    checkOutput("clean B.perr", {31'b0, bPerr}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h1, 4'd7, 32'h000000AA, 1'b1, 4'd7, 1'b1);
    idleCycle();
    checkOutput("bypass inj A.perr", {31'b0, aPerr}, 32'h1);
    idleCycle();
`endif

    repeat (4) idleCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
